// File: rtl/car_pkg.sv
// Shared car-link definitions: moving-state codes, command-byte layout, tx FSM encoding.
// CAR_CMD_TX_PARITY_EN adds the PARITY state for 8E1 framing.
package car_pkg;

  localparam logic [3:0] STOP         = 4'b0000;
  localparam logic [3:0] MOVE_FORWARD = 4'b0001;
  localparam logic [3:0] MOVE_BACK    = 4'b0010;
  localparam logic [3:0] TURN_LEFT    = 4'b0100;
  localparam logic [3:0] TURN_RIGHT   = 4'b1000;

  localparam int CMD_PL_BIT  = 4;
  localparam int CMD_DE_BIT  = 5;
  localparam int CMD_PWR_BIT = 6;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef CAR_CMD_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick is high on the last cycle of each CLKS_PER_BIT period.
// restart holds the count at zero so the next period starts cleanly.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/car_cmd_tx.sv
// UART transmitter for the car command byte: sends on command change and as a periodic keep-alive.
// Default 8N1; define CAR_CMD_TX_PARITY_EN for 8E1.
module car_cmd_tx
  import car_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 9600,
  parameter int REFRESH_CYCLES = 2_000_000
) (
  input  logic      sys_clk,
  input  logic      rst,
  input  logic      power,
  input  logic [3:0] moving_state,
  input  logic      pl_beacon_sig,
  input  logic      de_beacon_sig,
  output logic      tx,
  output logic      busy,
  output logic      frame_done,
  output tx_state_e dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

  tx_state_e     state, state_nxt;
  logic [7:0]    cmd, last_sent, shift_reg;
  logic [RW-1:0] refresh_cnt;
  logic [2:0]    bit_cnt;
  logic          pl_lat, de_lat;
  logic          load, tick;
`ifdef CAR_CMD_TX_PARITY_EN
  logic          parity_bit;
`endif

  always_comb begin
    cmd              = '0;
    cmd[CMD_PWR_BIT] = power;
    cmd[CMD_DE_BIT]  = de_lat;
    cmd[CMD_PL_BIT]  = pl_lat;
    cmd[3:0]         = power ? moving_state : STOP;
  end

  assign load = (state == TX_IDLE) && ((cmd != last_sent) || (refresh_cnt == REF_LAST));

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .sys_clk (sys_clk),
    .rst     (rst),
    .restart (state == TX_IDLE),
    .tick    (tick)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= TX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tx         = 1'b1;
    frame_done = 1'b0;
    case (state)
      TX_IDLE:  if (load) state_nxt = TX_START;
      TX_START: begin
        tx = 1'b0;
        if (tick) state_nxt = TX_DATA;
      end
      TX_DATA: begin
        tx = shift_reg[0];
`ifdef CAR_CMD_TX_PARITY_EN
        if (tick && bit_cnt == 3'd7) state_nxt = TX_PARITY;
`else
        if (tick && bit_cnt == 3'd7) state_nxt = TX_STOP;
`endif
      end
`ifdef CAR_CMD_TX_PARITY_EN
      TX_PARITY: begin
        tx = parity_bit;
        if (tick) state_nxt = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (tick) begin
          state_nxt  = TX_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  assign busy      = (state != TX_IDLE);
  assign dbg_state = state;

  // A beacon request arriving in the load cycle survives into the next frame.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pl_lat <= 1'b0;
      de_lat <= 1'b0;
    end else begin
      pl_lat <= (pl_lat & ~load) | pl_beacon_sig;
      de_lat <= (de_lat & ~load) | de_beacon_sig;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      last_sent   <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
    end else begin
      if (load) begin
        refresh_cnt <= '0;
      end else if (refresh_cnt != REF_LAST) begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
      if (load) begin
        last_sent <= cmd;
        shift_reg <= cmd;
        bit_cnt   <= '0;
      end else if (state == TX_DATA && tick) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
    end
  end

`ifdef CAR_CMD_TX_PARITY_EN
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      parity_bit <= 1'b0;
    end else if (load) begin
      parity_bit <= ^cmd;
    end
  end
`endif

endmodule
